// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the text-out FSM state encoding.
package aes_pkg;
  localparam int BLK_W = 128;
  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} tos_state_e;
endpackage

// File: rtl/aes_text_out_stage.sv
// Final AddRoundKey register plus a word-serial output stream of the
// 128-bit ciphertext, most significant word first, with overrun detect.
module aes_text_out_stage
  import aes_pkg::*;
#(
  parameter  int WORD_W = 32,
  localparam int NWORDS = BLK_W / WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,
  input  logic [BLK_W-1:0]  state_i,
  input  logic [BLK_W-1:0]  rkey_i,
  output logic [BLK_W-1:0]  text_out,
  output logic [BLK_W-1:0]  text_out_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);
  localparam int               IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  tos_state_e                       r_state;
  logic [BLK_W-1:0]                 r_text;
  logic [IDX_W-1:0]                 r_idx;
  logic                             r_overrun;
  logic [NWORDS-1:0][WORD_W-1:0]    w_words;
  logic                             w_last_hs;

  // Word NWORDS-1 sits in the top bits, so beat 0 is the MS word.
  assign w_words   = r_text;
  assign w_last_hs = out_valid & out_ready & (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_text    <= '0;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      // A done_i while draining (including the last-beat cycle) is dropped.
      if (done_i && r_state == DRAIN) r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          if (done_i) begin
            r_text  <= state_i ^ rkey_i;
            r_idx   <= '0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_last_hs) begin
            r_idx   <= '0;
            r_state <= IDLE;
          end else if (out_ready) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign text_out   = r_text;
  assign text_out_n = ~r_text;
  assign out_valid  = (r_state == DRAIN);
  assign busy       = (r_state == DRAIN);
  assign out_data   = w_words[LAST_IDX - r_idx];
  assign out_last   = out_valid & (r_idx == LAST_IDX);
  assign overrun    = r_overrun;
endmodule

// File: doc/aes_text_out_stage.md
AES_TEXT_OUT_STAGE -- requirements
Module: aes_text_out_stage

Interface
REQ-001 SHALL have parameter WORD_W, default 32, width of the streamed output word; legal values are 32 and 64.
REQ-002 SHALL have parameter NWORDS, default 128/WORD_W, the number of beats per block; it is derived and not overridden.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous and active-high.
REQ-005 SHALL have port done_i, input, 1, a one-cycle pulse from the final cipher round marking state_i/rkey_i valid.
REQ-006 SHALL have port state_i, input, 128, the state after final SubBytes/ShiftRows, byte 0 at bits [127:120].
REQ-007 SHALL have port rkey_i, input, 128, the last round key.
REQ-008 SHALL have port text_out, output, 128, the registered ciphertext (state_i XOR rkey_i).
REQ-009 SHALL have port text_out_n, output, 128, the bitwise complement of text_out, driven from the same flops; no separate register.
REQ-010 SHALL have port out_valid, output, 1, word stream valid.
REQ-011 SHALL have port out_ready, input, 1, word stream ready from the consumer.
REQ-012 SHALL have port out_data, output, WORD_W, the current word, most significant word first.
REQ-013 SHALL have port out_last, output, 1, asserted with the final beat of a block.
REQ-014 SHALL have port busy, output, 1, high while any beat of the current block is undelivered.
REQ-015 SHALL have port overrun, output, 1, sticky flag: done_i arrived while busy.

Function
REQ-016 SHALL, on a cycle with done_i=1 and busy=0, load text_out <= state_i ^ rkey_i at that edge; text_out is visible one cycle after done_i.
REQ-017 SHALL use a two-state FSM, IDLE and DRAIN: IDLE->DRAIN on an accepted done_i; DRAIN->IDLE on the handshake (out_valid & out_ready) of beat NWORDS-1.
REQ-018 SHALL hold out_valid=1 exactly while in DRAIN; the first beat is valid the cycle after done_i.
REQ-019 SHALL keep a beat index of width clog2(NWORDS): reset to 0 on capture, increment only on a handshake, and return to 0 after the last beat (no wrap-around while in IDLE).
REQ-020 SHALL drive out_data = text_out[127 - idx*WORD_W -: WORD_W] and out_last = (idx == NWORDS-1) & out_valid.
REQ-021 SHALL hold out_data, out_last and idx stable while out_valid=1 and out_ready=0; out_valid SHALL never drop before its handshake.
REQ-022 SHALL drive busy = (state == DRAIN).
REQ-023 SHALL, on done_i while busy, ignore the new data, leave text_out and the stream undisturbed, and set overrun; overrun clears only on reset.
REQ-024 SHALL treat a done_i arriving in the same cycle as the last-beat handshake as busy: the data is dropped, overrun is set, and the FSM returns to IDLE.
REQ-025 SHALL change text_out only on an accepted capture; text_out holds its value in IDLE indefinitely.

Reset
REQ-026 SHALL, on rst=1, immediately clear text_out to 0 (text_out_n to all-ones), the FSM to IDLE, idx to 0, and out_valid, out_last, busy and overrun to 0, independent of clk.
REQ-027 SHALL abandon a block that is mid-drain on reset, with no further beats emitted; the first done_i after reset release is captured normally.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, DRAIN) and the block width constant 128 in the shared package aes_pkg.
REQ-029 SHALL be a single module with no sub-modules; the XOR and word-select logic are inline.

Verification
REQ-030 SHALL cover basic streaming: state_i=0x00112233_44556677_8899AABB_CCDDEEFF, rkey_i=0, done_i pulse, out_ready=1 -> beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles, out_last on the 4th, busy low on the 5th.
REQ-031 SHALL cover the XOR: state_i=all-ones, rkey_i=0xFFFF0000 repeated -> text_out=0x0000FFFF repeated and text_out_n=0xFFFF0000 repeated.
REQ-032 SHALL cover backpressure: out_ready=0 for 3 cycles at beat 1 -> out_data holds 0x44556677 and out_valid stays 1; the stream resumes without loss.
REQ-033 SHALL cover overrun: a second done_i on beat 2, and a done_i on the last-beat handshake cycle -> overrun=1, text_out unchanged, remaining beats correct.
REQ-034 SHALL cover reset mid-operation: rst pulsed mid-cycle during beat 2 -> all outputs 0 (text_out_n all-ones) before the next clk edge; the next done_i streams 4 fresh beats.
REQ-035 SHALL cover WORD_W=64: the basic stimulus -> 2 beats, 0x0011223344556677 then 0x8899AABBCCDDEEFF with out_last.
